// File: rtl/frame_buffer_pkg.sv
// Shared types and default frame geometry for the frame-buffer write path.
package frame_buffer_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    CAPTURE = 1'b1
  } fb_state_t;

  localparam int FB_H_ACTIVE = 320;
  localparam int FB_V_ACTIVE = 240;
  localparam int FB_ADDR_W   = 18;

endpackage

// File: rtl/fb_coord_tracker.sv
// Expected-coordinate tracker for the camera stream, with a running intra-bank
// address offset so pixel addresses need no multiplier.
module fb_coord_tracker
  import frame_buffer_pkg::*;
#(
  parameter int H_ACTIVE = FB_H_ACTIVE,
  parameter int V_ACTIVE = FB_V_ACTIVE,
  parameter int ADDR_W   = FB_ADDR_W
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              clear,
  input  logic              load_first,
  input  logic              advance,
  output logic [10:0]       exp_h,
  output logic [9:0]        exp_v,
  output logic [ADDR_W-1:0] offset,
  output logic              last
);

  assign last = (exp_h == 11'(H_ACTIVE - 1)) && (exp_v == 10'(V_ACTIVE - 1));

  // load_first points at the pixel after (0,0), which the caller writes itself.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      exp_h  <= '0;
      exp_v  <= '0;
      offset <= '0;
    end else if (clear) begin
      exp_h  <= '0;
      exp_v  <= '0;
      offset <= '0;
    end else if (load_first) begin
      exp_h  <= 11'd1;
      exp_v  <= '0;
      offset <= ADDR_W'(1);
    end else if (advance) begin
      if (exp_h == 11'(H_ACTIVE - 1)) begin
        exp_h <= '0;
        exp_v <= exp_v + 10'd1;
      end else begin
        exp_h <= exp_h + 11'd1;
      end
      offset <= offset + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/frame_buffer_writer.sv
// Camera-to-BRAM frame writer with double buffering; the display bank flips
// only after the last write of a complete frame has been issued.
module frame_buffer_writer
  import frame_buffer_pkg::*;
#(
  parameter int H_ACTIVE = FB_H_ACTIVE,
  parameter int V_ACTIVE = FB_V_ACTIVE,
  parameter int ADDR_W   = FB_ADDR_W
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              pixel_valid_in,
  input  logic [10:0]       hcount_in,
  input  logic [9:0]        vcount_in,
  input  logic [15:0]       pixel_in,
  input  logic              freeze_in,
  output logic              we_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic [15:0]       data_out,
  output logic              read_bank_out,
  output logic              frame_done_out,
  output logic              sync_err_out
);

  // state   | meaning
  // IDLE    | waiting for (0,0) with freeze_in low
  // CAPTURE | writing an in-order frame into the bank opposite read_bank_out

  localparam logic [ADDR_W-1:0] FRAME_SIZE = ADDR_W'(H_ACTIVE * V_ACTIVE);

  fb_state_t         state;
  logic [10:0]       exp_h;
  logic [9:0]        exp_v;
  logic [ADDR_W-1:0] offset;
  logic              last;
  logic              in_range, is_origin, matched;
  logic              accept, start, advance, clear, err, commit;
  logic              commit_pending;
  logic              write_bank;
  logic [ADDR_W-1:0] wr_offset;

  assign in_range  = pixel_valid_in && (hcount_in < 11'(H_ACTIVE)) && (vcount_in < 10'(V_ACTIVE));
  assign is_origin = (hcount_in == '0) && (vcount_in == '0);
  assign matched   = (hcount_in == exp_h) && (vcount_in == exp_v);
  // A commit still pending has already claimed the flip, so target the bank it frees.
  assign write_bank = commit_pending ? read_bank_out : ~read_bank_out;
  assign wr_offset  = start ? '0 : offset;

  always_comb begin
    accept  = 1'b0;
    start   = 1'b0;
    advance = 1'b0;
    clear   = 1'b0;
    err     = 1'b0;
    commit  = 1'b0;
    if (in_range) begin
      case (state)
        IDLE: begin
          if (is_origin && !freeze_in) begin
            accept = 1'b1;
            start  = 1'b1;
          end
        end
        CAPTURE: begin
          if (matched) begin
            accept = 1'b1;
            if (last) begin
              commit = 1'b1;
              clear  = 1'b1;
            end else begin
              advance = 1'b1;
            end
          end else begin
            err = 1'b1;
            if (is_origin && !freeze_in) begin
              accept = 1'b1;
              start  = 1'b1;
            end else begin
              clear = 1'b1;
            end
          end
        end
        default: clear = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state          <= IDLE;
      we_out         <= 1'b0;
      addr_out       <= '0;
      data_out       <= '0;
      read_bank_out  <= 1'b0;
      frame_done_out <= 1'b0;
      sync_err_out   <= 1'b0;
      commit_pending <= 1'b0;
    end else begin
      if (start) begin
        state <= CAPTURE;
      end else if (commit || err) begin
        state <= IDLE;
      end
      we_out <= accept;
      if (accept) begin
        addr_out <= (write_bank ? FRAME_SIZE : '0) + wr_offset;
        data_out <= pixel_in;
      end
      sync_err_out   <= err;
      commit_pending <= commit;
      frame_done_out <= commit_pending;
      if (commit_pending) begin
        read_bank_out <= ~read_bank_out;
      end
    end
  end

  fb_coord_tracker #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .ADDR_W   (ADDR_W)
  ) u_tracker (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .clear      (clear),
    .load_first (start),
    .advance    (advance),
    .exp_h      (exp_h),
    .exp_v      (exp_v),
    .offset     (offset),
    .last       (last)
  );

endmodule
